regfile_scoreboard: RTL and testbench

Parametrised general-purpose register file for the CPU datapath: two combinational read ports, one synchronous write port, optional same-cycle write-to-read bypass, and a per-register pending-write scoreboard. Decode reserves each destination register at issue. Writeback releases it. The busy outputs drive the pipeline's read-after-write stall logic, so decode never reads a stale operand.

---
 rtl/regfile_scoreboard.sv | 107 ++++++++++
 tb/tb_regfile_scoreboard.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one synchronous write
// port, optional same-cycle write-to-read forwarding, and a per-register
// pending-write counter. Issue reserves destinations; writeback releases them.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int PEND_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_full
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] MAXP = '1;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [PEND_W-1:0] r_pend [NREGS];

    logic w_writable;
    logic w_release;
    logic w_rsv_acc;

    // Register 0 is hardwired when ZERO_REG is set, so it never takes data
    // and never holds a reservation.
    assign w_writable = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    // A write only releases a reservation when one is outstanding.
    assign w_release  = w_writable && (r_pend[wr_addr] != '0);
    assign rsv_full   = (r_pend[rsv_addr] == MAXP);
    assign w_rsv_acc  = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0)) && !rsv_full;

    // Data array: cleared asynchronously, written on the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_writable) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Pending counters: +1 on accepted reservation, -1 on release; both on
    // the same register cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_rsv_acc && (rsv_addr == ADDR_W'(i)) &&
                    !(w_release && (wr_addr == ADDR_W'(i)))) begin
                    r_pend[i] <= r_pend[i] + 1'b1;
                end else if (w_release && (wr_addr == ADDR_W'(i)) &&
                             !(w_rsv_acc && (rsv_addr == ADDR_W'(i)))) begin
                    r_pend[i] <= r_pend[i] - 1'b1;
                end
            end
        end
    end

    // Identical read/busy logic for both ports.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [ADDR_W-1:0] w_addr;
            logic              w_zero;
            logic              w_match;
            logic              w_hit;
            logic [PEND_W-1:0] w_pend;
            logic [PEND_W-1:0] w_pend_eff;
            logic [DATA_W-1:0] w_data;
            logic              w_busy;

            assign w_addr     = (gi == 0) ? rd_addr_a : rd_addr_b;
            assign w_zero     = (ZERO_REG != 0) && (w_addr == '0);
            assign w_match    = w_writable && (wr_addr == w_addr);
            assign w_pend     = r_pend[w_addr];
            // The forwarded write also counts as the release it carries.
            assign w_hit      = (BYPASS != 0) && w_match && (w_pend != '0);
            assign w_pend_eff = w_pend - PEND_W'(w_hit);
            assign w_data     = w_zero ? '0 :
                                ((BYPASS != 0) && w_match) ? wr_data : r_regs[w_addr];
            assign w_busy     = !w_zero && (w_pend_eff != '0);
        end
    endgenerate

    assign rd_data_a = g_port[0].w_data;
    assign rd_data_b = g_port[1].w_data;
    assign busy_a    = g_port[0].w_busy;
    assign busy_b    = g_port[1].w_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard (default parameters): directed scenarios
// followed by random traffic, all outputs compared against a reference model.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        busy_a;
    logic        busy_b;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rsv_full;

    int checks = 0;
    int errors = 0;

    // Reference state: register contents and outstanding write counts.
    logic [31:0] m_regs [32];
    int          m_pend [32];

    regfile_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rsv_full  (rsv_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 0;
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wr_en && wr_addr != 0 && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        int n;
        if (a == 0) return 1'b0;
        n = m_pend[a];
        if (wr_en && wr_addr == a && n > 0) n = n - 1;
        return n > 0;
    endfunction

    // Apply one cycle's inputs (called just after a falling edge).
    task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic re, input logic [4:0] ra,
                          input logic [4:0] aa, input logic [4:0] ab);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra;
        rd_addr_a = aa; rd_addr_b = ab;
        #1;
    endtask

    task automatic model_checks(input string tag);
        chk({tag, ".rd_a"}, rd_data_a, exp_rd(rd_addr_a));
        chk({tag, ".rd_b"}, rd_data_b, exp_rd(rd_addr_b));
        chk({tag, ".busy_a"}, {31'b0, busy_a}, {31'b0, exp_busy(rd_addr_a)});
        chk({tag, ".busy_b"}, {31'b0, busy_b}, {31'b0, exp_busy(rd_addr_b)});
        chk({tag, ".full"}, {31'b0, rsv_full}, {31'b0, m_pend[rsv_addr] == 3});
    endtask

    // Advance one clock and apply the same inputs to the model.
    task automatic clk_step();
        int  old_w;
        int  old_r;
        bit  acc;
        bit  rel;
        old_w = m_pend[wr_addr];
        old_r = m_pend[rsv_addr];
        acc = rsv_en && rsv_addr != 0 && old_r < 3;
        rel = wr_en && wr_addr != 0 && old_w > 0;
        @(posedge clk);
        if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
        if (acc) m_pend[rsv_addr] = m_pend[rsv_addr] + 1;
        if (rel) m_pend[wr_addr] = m_pend[wr_addr] - 1;
        @(negedge clk);
    endtask

    task automatic cyc(input string tag, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic re, input logic [4:0] ra,
                       input logic [4:0] aa, input logic [4:0] ab);
        set_in(we, wa, wd, re, ra, aa, ab);
        model_checks(tag);
        clk_step();
    endtask

    initial begin
        rst = 1'b1;
        model_clear();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2);
        chk("rst.rd_a", rd_data_a, 32'h0);
        chk("rst.busy_a", {31'b0, busy_a}, 32'h0);
        chk("rst.full", {31'b0, rsv_full}, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // All registers read back zero after reset.
        for (int i = 0; i < 32; i += 2) begin
            set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(i + 1));
            chk("zero.rd_a", rd_data_a, 32'h0);
            chk("zero.rd_b", rd_data_b, 32'h0);
            clk_step();
        end

        // Register 0 ignores writes and reservations.
        cyc("r0.wr", 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0, 5'd0);
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("r0.rd", rd_data_a, 32'h0);
        chk("r0.busy", {31'b0, busy_a}, 32'h0);
        clk_step();

        // Same-cycle forwarding of a write.
        set_in(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd5);
        chk("byp.r5", rd_data_a, 32'h12345678);
        model_checks("byp");
        clk_step();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        chk("arr.r5", rd_data_a, 32'h12345678);
        clk_step();

        // Reserve r7, then release it with a forwarded write.
        cyc("rsv7", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd7);
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7);
        chk("rsv7.busy", {31'b0, busy_b}, 32'h1);
        clk_step();
        set_in(1'b1, 5'd7, 32'h000000A5, 1'b0, 5'd0, 5'd0, 5'd7);
        chk("rel7.busy", {31'b0, busy_b}, 32'h0);
        chk("rel7.rd", rd_data_b, 32'h000000A5);
        clk_step();

        // Saturate r3, check the refusal, then drain it.
        for (int i = 0; i < 3; i++) cyc("sat", 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
        chk("sat.full", {31'b0, rsv_full}, 32'h1);
        clk_step();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'd3, 32'(i + 100), 1'b0, 5'd3, 5'd3, 5'd0);
            chk("drain.busy", {31'b0, busy_a}, {31'b0, i != 2});
            model_checks("drain");
            clk_step();
        end

        // Simultaneous reservation and release on r9; unreserved write to r10.
        cyc("r9.rsv", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0);
        cyc("r9.both", 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd9, 5'd9);
        set_in(1'b1, 5'd10, 32'h1010, 1'b0, 5'd0, 5'd9, 5'd10);
        chk("r9.busy", {31'b0, busy_a}, 32'h1);
        chk("r10.busy", {31'b0, busy_b}, 32'h0);
        clk_step();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd10);
        chk("r10.rd", rd_data_b, 32'h1010);
        chk("r10.busy2", {31'b0, busy_b}, 32'h0);
        clk_step();

        // Reset between edges discards reservations and data.
        cyc("r4", 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd0);
        cyc("r6", 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd4, 5'd6);
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd5);
        chk("pre.busy4", {31'b0, busy_a}, 32'h1);
        rst = 1'b1;
        #1;
        model_clear();
        chk("mid.busy4", {31'b0, busy_a}, 32'h0);
        chk("mid.rd5", rd_data_b, 32'h0);
        model_checks("mid");
        #1 rst = 1'b0;
        clk_step();
        cyc("post.wr4", 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd4, 5'd4);
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
        chk("post.busy4", {31'b0, busy_a}, 32'h0);
        chk("post.rd4", rd_data_a, 32'h44);
        clk_step();

        // Random traffic concentrated on a few registers to force collisions.
        for (int n = 0; n < 400; n++) begin
            cyc("rnd", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
